// File: rtl/cas_player.sv
// MSX cassette playback transmitter: turns tagged items (data byte, short or
// long header, silence) into the 1200-baud FSK square wave that feeds the
// machine's cassette input. All waveform timing advances on ce_i ticks while
// the cassette motor is running.
module cas_player #(
    parameter int HALF_2400 = 746,
    parameter int HALF_1200 = 1492,
    parameter int SHORT_HDR = 4000,
    parameter int LONG_HDR  = 16000
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       ce_i,
    input  logic       motor_i,
    input  logic [7:0] data_i,
    input  logic [1:0] tag_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       cas_audio_o,
    output logic       busy_o
);

    // Longest count held by the shared item counter: header cycles or the
    // tick length of a maximum (255 bit times) silence.
    localparam int SIL_MAX = 255 * 2 * HALF_1200;
    localparam int CNT_MAX = (LONG_HDR > SIL_MAX) ? LONG_HDR : SIL_MAX;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int HALF_W  = $clog2(HALF_1200 + 1);

    localparam logic [HALF_W-1:0] LAST_2400  = HALF_W'(HALF_2400 - 1);
    localparam logic [HALF_W-1:0] LAST_1200  = HALF_W'(HALF_1200 - 1);
    localparam logic [CNT_W-1:0]  LAST_SHORT = CNT_W'(SHORT_HDR - 1);
    localparam logic [CNT_W-1:0]  LAST_LONG  = CNT_W'(LONG_HDR - 1);
    localparam logic [CNT_W-1:0]  BIT_TICKS  = CNT_W'(2 * HALF_1200);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_START,
        S_DATA,
        S_STOP,
        S_SIL
    } state_t;

    state_t            state;
    logic [HALF_W-1:0] half_cnt;
    logic [1:0]        half_idx;
    logic [2:0]        bit_idx;
    logic [CNT_W-1:0]  long_cnt;
    logic [7:0]        shreg;
    logic              hdr_long;

    logic              take;
    logic              advance;
    logic              cur_bit;
    logic              half_end;
    logic [HALF_W-1:0] half_last;
    logic [1:0]        halves_last;
    logic [CNT_W-1:0]  sil_ticks;
    logic [CNT_W-1:0]  hdr_last;

    // Decode the handshake, the tick gate and the shape of the current bit:
    // a '1' is two 2400 Hz cycles (four short halves), a '0' one 1200 Hz
    // cycle (two long halves), so every bit spans the same tick count.
    always_comb begin
        take    = valid_i & ready_o;
        advance = ce_i & motor_i;
        case (state)
            S_START: cur_bit = 1'b0;
            S_DATA:  cur_bit = shreg[0];
            default: cur_bit = 1'b1;
        endcase
        half_last   = cur_bit ? LAST_2400 : LAST_1200;
        halves_last = cur_bit ? 2'd3 : 2'd1;
        half_end    = (half_cnt == half_last);
        sil_ticks   = CNT_W'(shreg) * BIT_TICKS;
        hdr_last    = hdr_long ? LAST_LONG : LAST_SHORT;
    end

    // Ready is offered one cycle after an idle cycle with the motor running,
    // and withdrawn as soon as an item has been taken.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ready_o <= 1'b0;
        end else begin
            ready_o <= (state == S_IDLE) && motor_i && !take;
        end
    end

    // Item sequencer and waveform generator; a stopped motor or a low ce_i
    // freezes every counter and the output level so playback resumes in phase.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= S_IDLE;
            busy_o      <= 1'b0;
            cas_audio_o <= 1'b0;
            half_cnt    <= '0;
            half_idx    <= '0;
            bit_idx     <= '0;
            long_cnt    <= '0;
            shreg       <= '0;
            hdr_long    <= 1'b0;
        end else if (state == S_IDLE) begin
            if (take) begin
                shreg    <= data_i;
                hdr_long <= (tag_i == 2'b10);
                half_cnt <= '0;
                half_idx <= '0;
                bit_idx  <= '0;
                long_cnt <= '0;
                busy_o   <= 1'b1;
                case (tag_i)
                    2'b00: begin
                        state       <= S_START;
                        cas_audio_o <= 1'b1;
                    end
                    2'b01, 2'b10: begin
                        state       <= S_HDR;
                        cas_audio_o <= 1'b1;
                    end
                    default: begin
                        state       <= S_SIL;
                        cas_audio_o <= 1'b0;
                    end
                endcase
            end
        end else if (advance) begin
            case (state)
                S_SIL: begin
                    if (sil_ticks == '0 || long_cnt == sil_ticks - 1'b1) begin
                        state       <= S_IDLE;
                        busy_o      <= 1'b0;
                        cas_audio_o <= 1'b0;
                    end else begin
                        long_cnt <= long_cnt + 1'b1;
                    end
                end
                S_HDR: begin
                    if (half_end) begin
                        half_cnt <= '0;
                        if (cas_audio_o) begin
                            cas_audio_o <= 1'b0;
                        end else if (long_cnt == hdr_last) begin
                            state  <= S_IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            long_cnt    <= long_cnt + 1'b1;
                            cas_audio_o <= 1'b1;
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                S_START, S_DATA, S_STOP: begin
                    if (half_end) begin
                        half_cnt    <= '0;
                        cas_audio_o <= ~cas_audio_o;
                        if (half_idx == halves_last) begin
                            half_idx <= '0;
                            case (state)
                                S_START: begin
                                    state <= S_DATA;
                                end
                                S_DATA: begin
                                    shreg <= {1'b0, shreg[7:1]};
                                    if (bit_idx == 3'd7) begin
                                        state   <= S_STOP;
                                        bit_idx <= '0;
                                    end else begin
                                        bit_idx <= bit_idx + 1'b1;
                                    end
                                end
                                default: begin
                                    if (bit_idx == 3'd1) begin
                                        state       <= S_IDLE;
                                        busy_o      <= 1'b0;
                                        cas_audio_o <= 1'b0;
                                    end else begin
                                        bit_idx <= bit_idx + 1'b1;
                                    end
                                end
                            endcase
                        end else begin
                            half_idx <= half_idx + 1'b1;
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    busy_o      <= 1'b0;
                    cas_audio_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
